score_bcd_counter: RTL and testbench
====================================

SCORE_BCD_COUNTER -- requirements
Module: score_bcd_counter

Interface
REQ-001 The block SHALL have parameter INC, default 1, meaning the points added per eat pulse; legal range is 1..9.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port eat, input, 1 bit: single-cycle pulse, snake consumed food.
REQ-005 The block SHALL have port game_over, input, 1 bit: single-cycle pulse, current game ended.
REQ-006 The block SHALL have port clear, input, 1 bit: single-cycle pulse, start a new game.
REQ-007 The block SHALL have ports score_d0, score_d1, score_d2, each output, 4 bits: current score as BCD ones/tens/hundreds, one 4-bit code per seven-segment digit decoder.
REQ-008 The block SHALL have ports high_d0, high_d1, high_d2, each output, 4 bits: high score as BCD ones/tens/hundreds.
REQ-009 The block SHALL have port playing, output, 1 bit: 1 in state PLAY, 0 in state OVER.
REQ-010 The block SHALL have port new_high, output, 1 bit: sticky flag, the last game_over raised the high score.

Function
REQ-011 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-012 The state machine SHALL have two states, PLAY and OVER.
REQ-013 In PLAY, game_over=1 SHALL cause a transition to OVER on the next edge.
REQ-014 In either state, clear=1 SHALL cause a transition to PLAY on the next edge.
REQ-015 In PLAY, eat=1 SHALL add INC to the score, with the result visible on score_d* exactly one clock edge later (latency 1).
REQ-016 The score addition SHALL be decimal: ones digit plus INC; when the sum exceeds 9, subtract 10 and carry into tens; tens carries into hundreds the same way.
REQ-017 Every score digit and every high digit SHALL always hold a value in 0..9; codes 10..15 SHALL never appear.
REQ-018 If score + INC would exceed 999, the score SHALL saturate at 999, with no wrap to 000.
REQ-019 In OVER, eat SHALL be ignored and the score SHALL hold.
REQ-020 game_over in PLAY SHALL compare the registered score (before any same-cycle eat) against the high score.
REQ-021 If that score is strictly greater than the high score, high SHALL load the score on the same edge and new_high SHALL be set to 1; otherwise high SHALL be unchanged and new_high SHALL be set to 0.
REQ-022 game_over in OVER SHALL be ignored, with no compare and no flag change.
REQ-023 clear SHALL zero the score digits and new_high on the next edge and SHALL leave the high score unchanged.
REQ-024 Simultaneous clear and eat: clear SHALL win, and the score SHALL become 000.
REQ-025 Simultaneous eat and game_over in PLAY: the eat SHALL be discarded, the compare SHALL use the pre-eat score, and the state SHALL go to OVER.
REQ-026 Simultaneous clear and game_over in PLAY: the compare/high update SHALL occur using the pre-clear score, the score SHALL clear, the state SHALL remain PLAY, and new_high SHALL reflect the compare result.
REQ-027 Inputs held high for multiple cycles SHALL act once per cycle; no edge detection is performed in this block.

Reset
REQ-028 resetn=0 SHALL, immediately and independent of clock, force: score_d*=0, high_d*=0, state PLAY (playing=1), new_high=0.
REQ-029 Reset asserted mid-game SHALL discard both score and high score; there is no retention across reset.
REQ-030 After resetn deasserts, the first active edge SHALL process inputs normally.

Verification
REQ-031 Scenario: reset, 12 eat pulses (INC=1) -> score digits 2,1,0 (d0,d1,d2); playing=1.
REQ-032 Scenario: INC=7, score 095, one eat -> score 102, all digits valid BCD.
REQ-033 Scenario: score 998, INC=1, three eats -> score 999 held, no wrap.
REQ-034 Scenario: score 045, high 030, game_over -> high 045, new_high=1, playing=0; then one eat -> score stays 045; then clear -> score 000, high 045, new_high=0, playing=1.
REQ-035 Scenario: score 020, high 045, eat+game_over same cycle -> score 020, high 045, new_high=0, playing=0.
REQ-036 Scenario: score 300, high 100, resetn pulsed low between edges -> all digits 0 immediately, new_high=0, playing=1.

Source files
------------

// File: rtl/score_bcd_counter.sv
// Three-digit BCD score keeper with a high-score register for a snake game.
// Every output comes straight from a flop; all input handling lives in the next-state logic.
module score_bcd_counter #(
  parameter int unsigned INC = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       eat,
  input  logic       game_over,
  input  logic       clear,
  output logic [3:0] score_d0,
  output logic [3:0] score_d1,
  output logic [3:0] score_d2,
  output logic [3:0] high_d0,
  output logic [3:0] high_d1,
  output logic [3:0] high_d2,
  output logic       playing,
  output logic       new_high
);

  // state | meaning
  // PLAY  | game running: eat adds points, game_over ends the game
  // OVER  | game ended: score frozen, eat and game_over ignored
  typedef enum logic {
    OVER = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [4:0] INC_W = 5'(INC);

  state_t      state_q, state_d;
  logic [11:0] score_q, score_d;
  logic [11:0] high_q, high_d;
  logic        new_high_q, new_high_d;
  logic        end_game;

  // Digit-wise decimal add; a carry out of the hundreds digit pins the score at 999.
  function automatic logic [11:0] bcd_add_sat(input logic [11:0] s);
    logic [4:0]  sum;
    logic        carry;
    logic [11:0] r;
    sum = {1'b0, s[3:0]} + INC_W;
    carry = (sum > 5'd9);
    if (carry) sum = sum - 5'd10;
    r[3:0] = sum[3:0];
    sum = {1'b0, s[7:4]} + {4'd0, carry};
    carry = (sum > 5'd9);
    if (carry) sum = sum - 5'd10;
    r[7:4] = sum[3:0];
    sum = {1'b0, s[11:8]} + {4'd0, carry};
    if (sum > 5'd9) r = 12'h999;
    else            r[11:8] = sum[3:0];
    return r;
  endfunction

  // With every digit held in 0..9, packed BCD orders the same as the decimal value,
  // so a plain unsigned compare of the 12-bit words is a correct score compare.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    end_game   = game_over && (state_q == PLAY);

    if (end_game) begin
      state_d = OVER;
      if (score_q > high_q) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end else begin
        new_high_d = 1'b0;
      end
    end

    if (clear) begin
      state_d = PLAY;
      score_d = 12'h000;
      if (!end_game) new_high_d = 1'b0;
    end else if ((state_q == PLAY) && eat && !game_over) begin
      score_d = bcd_add_sat(score_q);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= PLAY;
      score_q    <= 12'h000;
      high_q     <= 12'h000;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  assign score_d0 = score_q[3:0];
  assign score_d1 = score_q[7:4];
  assign score_d2 = score_q[11:8];
  assign high_d0  = high_q[3:0];
  assign high_d1  = high_q[7:4];
  assign high_d2  = high_q[11:8];
  assign playing  = (state_q == PLAY);
  assign new_high = new_high_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter: unit 0 runs with INC=1, unit 1 with INC=7.
// Stimulus pushes expected post-edge values; the monitor pops and compares after each edge.
module tb_score_bcd_counter;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  logic eat_a = 0, game_over_a = 0, clear_a = 0;
  logic eat_b = 0, game_over_b = 0, clear_b = 0;
  logic [3:0] sa0, sa1, sa2, ha0, ha1, ha2;
  logic [3:0] sb0, sb1, sb2, hb0, hb1, hb2;
  logic playing_a, new_high_a, playing_b, new_high_b;

  int checks = 0;
  int errors = 0;
  int step_id = 0;

  typedef struct {
    int unit;
    int id;
    int score;
    int high;
    bit nh;
    bit pl;
  } exp_t;

  exp_t q[$];

  score_bcd_counter #(.INC(1)) dut_a (
    .clock(clock), .resetn(resetn), .eat(eat_a), .game_over(game_over_a), .clear(clear_a),
    .score_d0(sa0), .score_d1(sa1), .score_d2(sa2),
    .high_d0(ha0), .high_d1(ha1), .high_d2(ha2),
    .playing(playing_a), .new_high(new_high_a)
  );

  score_bcd_counter #(.INC(7)) dut_b (
    .clock(clock), .resetn(resetn), .eat(eat_b), .game_over(game_over_b), .clear(clear_b),
    .score_d0(sb0), .score_d1(sb1), .score_d2(sb2),
    .high_d0(hb0), .high_d1(hb1), .high_d2(hb2),
    .playing(playing_b), .new_high(new_high_b)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check12(input string nm, input int unit, input int id,
                         input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s unit %0d step %0d: got %h want %h", nm, unit, id, act, req);
    end
  endtask

  task automatic check1(input string nm, input int unit, input int id,
                        input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s unit %0d step %0d: got %b want %b", nm, unit, id, act, req);
    end
  endtask

  task automatic check_unit(input int unit, input int id, input int score, input int high,
                            input bit nh, input bit pl);
    if (unit == 0) begin
      check12("score", unit, id, {sa2, sa1, sa0}, to_bcd(score));
      check12("high", unit, id, {ha2, ha1, ha0}, to_bcd(high));
      check1("new_high", unit, id, new_high_a, nh);
      check1("playing", unit, id, playing_a, pl);
    end else begin
      check12("score", unit, id, {sb2, sb1, sb0}, to_bcd(score));
      check12("high", unit, id, {hb2, hb1, hb0}, to_bcd(high));
      check1("new_high", unit, id, new_high_b, nh);
      check1("playing", unit, id, playing_b, pl);
    end
  endtask

  task automatic drive(input int unit, input bit e, input bit g, input bit c);
    eat_a = 0; game_over_a = 0; clear_a = 0;
    eat_b = 0; game_over_b = 0; clear_b = 0;
    if (unit == 0) begin
      eat_a = e; game_over_a = g; clear_a = c;
    end else if (unit == 1) begin
      eat_b = e; game_over_b = g; clear_b = c;
    end
  endtask

  // One clock of stimulus plus the values expected right after the following edge.
  task automatic step(input int unit, input bit e, input bit g, input bit c,
                      input int score, input int high, input bit nh, input bit pl);
    exp_t x;
    @(negedge clock);
    drive(unit, e, g, c);
    step_id++;
    x.unit = unit; x.id = step_id; x.score = score; x.high = high; x.nh = nh; x.pl = pl;
    q.push_back(x);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(negedge clock);
      drive(-1, 0, 0, 0);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        #1;
        check_unit(e.unit, e.id, e.score, e.high, e.nh, e.pl);
      end
    end
  end

  initial begin : stimulus
    int v;
    #2 resetn = 1'b0;
    #1;
    check_unit(0, 0, 0, 0, 0, 1);
    check_unit(1, 0, 0, 0, 0, 1);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 1; i <= 12; i++) step(0, 1, 0, 0, i, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 1);

    for (int i = 1; i <= 30; i++) step(0, 1, 0, 0, i, 0, 0, 1);
    step(0, 0, 1, 0, 30, 30, 1, 0);
    step(0, 0, 0, 1, 0, 30, 0, 1);

    for (int i = 1; i <= 45; i++) step(0, 1, 0, 0, i, 30, 0, 1);
    step(0, 0, 1, 0, 45, 45, 1, 0);
    step(0, 1, 0, 0, 45, 45, 1, 0);
    step(0, 0, 1, 0, 45, 45, 1, 0);
    step(0, 0, 0, 1, 0, 45, 0, 1);

    for (int i = 1; i <= 20; i++) step(0, 1, 0, 0, i, 45, 0, 1);
    step(0, 1, 1, 0, 20, 45, 0, 0);
    step(0, 0, 0, 1, 0, 45, 0, 1);

    for (int i = 1; i <= 50; i++) step(0, 1, 0, 0, i, 45, 0, 1);
    step(0, 0, 1, 1, 0, 50, 1, 1);

    for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, i, 50, 1, 1);
    step(0, 1, 0, 1, 0, 50, 0, 1);

    for (int i = 1; i <= 100; i++) step(0, 1, 0, 0, i, 50, 0, 1);
    step(0, 0, 1, 0, 100, 100, 1, 0);
    step(0, 0, 0, 1, 0, 100, 0, 1);
    for (int i = 1; i <= 300; i++) step(0, 1, 0, 0, i, 100, 0, 1);

    drain();
    @(negedge clock);
    drive(-1, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    check_unit(0, -1, 0, 0, 0, 1);
    check_unit(1, -1, 0, 0, 0, 1);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 1; i <= 998; i++) step(0, 1, 0, 0, i, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 999, 0, 0, 1);
    step(0, 0, 1, 0, 999, 999, 1, 0);

    for (int n = 1; n <= 144; n++) begin
      v = (7 * n > 999) ? 999 : 7 * n;
      step(1, 1, 0, 0, v, 0, 0, 1);
    end
    step(1, 0, 1, 0, 999, 999, 1, 0);

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
